// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map and pipeline FSM states.
// The combinational 8-bit ALU and alu_pipe both import these opcodes.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {
      IDLE,
      MUL
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath: one partial product per step, multiplier LSB first.
// done strobes during the final step; product then holds the full 2*WIDTH-bit result.
module alu_mul_iter #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 step,
   input  logic [WIDTH-1:0]     b,
   input  logic [WIDTH-1:0]     c,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [SHW-1:0]     count_q;

   always_comb begin
      acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
      product = acc_d;
      done    = step && (count_q == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else if (start) begin
         mcand_q  <= {{WIDTH{1'b0}}, b};
         mplier_q <= c;
         acc_q    <= '0;
         count_q  <= SHW'(WIDTH - 1);
      end else if (step) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         count_q  <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU stage: single-cycle ops load the output register directly, MUL iterates
// WIDTH cycles in alu_mul_iter. Only out_ready reaches in_ready combinationally.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   input  logic [2:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_ovf,
   output logic             busy
);

   state_t state_q, state_d;

   logic             out_valid_q;
   logic [WIDTH-1:0] alu_out_q;
   logic             zero_q, carry_q, ovf_q;

   logic             accept, load_single, start_mul, mul_done;
   logic [WIDTH-1:0] res;
   logic             res_carry, res_ovf;
   logic [WIDTH:0]   sum_ext, diff_ext;
   logic [2*WIDTH-1:0] product;

   assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept      = in_valid && in_ready;
   assign start_mul   = accept && (alu_op == OP_MUL);
   assign load_single = accept && (alu_op != OP_MUL);

   alu_mul_iter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (start_mul),
      .step    (state_q == MUL),
      .b       (in_b),
      .c       (in_c),
      .done    (mul_done),
      .product (product)
   );

   always_comb begin
      sum_ext   = {1'b0, in_b} + {1'b0, in_c};
      diff_ext  = {1'b0, in_b} - {1'b0, in_c};
      res       = '0;
      res_carry = 1'b0;
      res_ovf   = 1'b0;
      case (alu_op)
         OP_ADD: begin
            res       = sum_ext[WIDTH-1:0];
            res_carry = sum_ext[WIDTH];
            res_ovf   = (in_b[WIDTH-1] == in_c[WIDTH-1]) && (res[WIDTH-1] != in_b[WIDTH-1]);
         end
         OP_SUB: begin
            res       = diff_ext[WIDTH-1:0];
            res_carry = diff_ext[WIDTH];
            res_ovf   = (in_b[WIDTH-1] != in_c[WIDTH-1]) && (res[WIDTH-1] != in_b[WIDTH-1]);
         end
         OP_AND: res = in_b & in_c;
         OP_OR:  res = in_b | in_c;
         OP_SLT: res = {{(WIDTH-1){1'b0}}, (in_b < in_c)};
         OP_XOR: res = in_b ^ in_c;
         // Amounts at or beyond WIDTH shift everything out.
         OP_SLL: res = (in_c >= WIDTH'(WIDTH)) ? '0 : (in_b << in_c[SHW-1:0]);
         default: res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_mul) state_d = MUL;
         MUL:     if (mul_done)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         alu_out_q   <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_single) begin
            out_valid_q <= 1'b1;
            alu_out_q   <= res;
            zero_q      <= (res == '0);
            carry_q     <= res_carry;
            ovf_q       <= res_ovf;
         end else if (mul_done) begin
            out_valid_q <= 1'b1;
            alu_out_q   <= product[WIDTH-1:0];
            zero_q      <= (product[WIDTH-1:0] == '0);
            carry_q     <= |product[2*WIDTH-1:WIDTH];
            ovf_q       <= 1'b0;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign alu_out    = alu_out_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign flag_ovf   = ovf_q;
   assign busy       = (state_q == MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8 with hand-computed expectations.
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_b, in_c;
   logic [2:0] alu_op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] alu_out;
   logic       flag_zero, flag_carry, flag_ovf, busy;

   int errors = 0;
   int checks = 0;
   logic seen;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_b       (in_b),
      .in_c       (in_c),
      .alu_op     (alu_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_out    (alu_out),
      .flag_zero  (flag_zero),
      .flag_carry (flag_carry),
      .flag_ovf   (flag_ovf),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request, take one edge, then withdraw it.
   task automatic issue(input logic [2:0] op, input logic [7:0] b, input logic [7:0] c);
      alu_op   = op;
      in_b     = b;
      in_c     = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic chk_res(input string tag, input logic [7:0] v, input logic z,
                          input logic cy, input logic ov);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".out"},   32'(alu_out),   32'(v));
      chk({tag, ".zero"},  32'(flag_zero), 32'(z));
      chk({tag, ".carry"}, 32'(flag_carry), 32'(cy));
      chk({tag, ".ovf"},   32'(flag_ovf),  32'(ov));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_b = '0; in_c = '0; alu_op = '0; out_ready = 1'b1;
      #1;
      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.out",   32'(alu_out),   32'd0);
      chk("rst.flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'd0);
      chk("rst.busy",  32'(busy),      32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      chk("add.ready", 32'(in_ready), 32'd1);
      chk("add.pre_valid", 32'(out_valid), 32'd0);
      issue(3'b000, 8'hFF, 8'h01);
      chk_res("add", 8'h00, 1'b1, 1'b1, 1'b0);

      issue(3'b001, 8'h80, 8'h01);
      chk_res("sub1", 8'h7F, 1'b0, 1'b0, 1'b1);
      issue(3'b001, 8'h01, 8'h02);
      chk_res("sub2", 8'hFF, 1'b0, 1'b1, 1'b0);
      issue(3'b100, 8'h02, 8'hFE);
      chk_res("slt", 8'h01, 1'b0, 1'b0, 1'b0);
      issue(3'b101, 8'hA5, 8'hFF);
      chk_res("xor", 8'h5A, 1'b0, 1'b0, 1'b0);
      issue(3'b110, 8'h01, 8'h07);
      chk_res("sll7", 8'h80, 1'b0, 1'b0, 1'b0);
      issue(3'b110, 8'h01, 8'h08);
      chk_res("sll8", 8'h00, 1'b1, 1'b0, 1'b0);
      issue(3'b010, 8'hF0, 8'h3C);
      chk_res("and", 8'h30, 1'b0, 1'b0, 1'b0);

      // MUL 0F x 11: result exactly 8 edges after acceptance.
      issue(3'b111, 8'h0F, 8'h11);
      for (int i = 0; i < 7; i++) begin
         chk("mul1.busy",  32'(busy),      32'd1);
         chk("mul1.ready", 32'(in_ready),  32'd0);
         chk("mul1.early", 32'(out_valid), 32'd0);
         tick();
      end
      chk("mul1.busy_last", 32'(busy), 32'd1);
      tick();
      chk_res("mul1", 8'hFF, 1'b0, 1'b0, 1'b0);
      chk("mul1.idle", 32'(busy), 32'd0);

      issue(3'b111, 8'h10, 8'h10);
      for (int i = 0; i < 8; i++) tick();
      chk_res("mul2", 8'h00, 1'b1, 1'b1, 1'b0);
      tick();
      chk("drain.valid", 32'(out_valid), 32'd0);

      // Backpressure: second request stalls until the held result drains.
      out_ready = 1'b0;
      issue(3'b000, 8'h03, 8'h04);
      chk_res("bp1", 8'h07, 1'b0, 1'b0, 1'b0);
      alu_op = 3'b011; in_b = 8'hF0; in_c = 8'h0F; in_valid = 1'b1;
      #1;
      chk("bp.stall_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp.hold", 32'(alu_out), 32'h07);
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      #1;
      chk("bp.ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk_res("bp2", 8'hFF, 1'b0, 1'b0, 1'b0);
      tick();
      chk("bp.drained", 32'(out_valid), 32'd0);

      // Reset three cycles into a MUL discards it.
      issue(3'b111, 8'h0F, 8'h11);
      tick(); tick();
      chk("rmul.busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rmul.valid", 32'(out_valid), 32'd0);
      chk("rmul.out",   32'(alu_out),   32'd0);
      chk("rmul.flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'd0);
      chk("rmul.busy0", 32'(busy),      32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rmul.ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid || busy) seen = 1'b1;
      end
      chk("rmul.no_result", 32'(seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
